// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose : FSM state encoding, reset level, zero word, load/store encodings
//           and the byte-lane mask helper shared by the responder files.
// Ports   : none (package).
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic        OP_LOAD    = 1'b0;
  localparam logic        OP_STORE   = 1'b1;

  // Expands the 4 byte-lane enables into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = ZERO_WORD;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// rtl/dmem_ram_array.sv - single-port synchronous word array with byte-lane writes
//
// Purpose : backing store for dmem_responder. One access per enabled cycle;
//           the read word is registered and holds until the next access.
//           Contents are deliberately not reset.
// Ports   : clk_i   clock
//           en_i    access enable
//           we_i    byte-lane write enables (only honoured when en_i=1)
//           addr_i  word index
//           wdata_i write data
//           rdata_o registered read data (old contents on a write access)
module dmem_ram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder for the MEM stage
//
// Purpose : accepts one load/store at a time, inserts WAIT_CYCLES wait states,
//           accesses dmem_ram_array on the edge entering RESP and holds the
//           response until rsp_ready_i. Optional access checking is enabled by
//           defining DMEM_ERR_CHECK_EN (misaligned, empty sel, out-of-range).
// Ports   : clk, rst (async active-high)
//           req_i/req_we_i/req_addr_i/req_sel_i/req_wdata_i  request in
//           req_ready_o                                      accept strobe (IDLE only)
//           rsp_valid_o/rsp_rdata_o/rsp_err_o                response out
//           rsp_ready_i                                      response taken
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  input  logic        rsp_ready_i
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        go_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= OP_LOAD;
      addr_q  <= ZERO_WORD;
      sel_q   <= 4'd0;
      wdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          sel_d   = req_sel_i;
          wdata_d = req_wdata_i;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge itself, before
  // the request registers are loaded, so the array is fed from the live inputs
  // while in IDLE and from the latched copy otherwise.
  logic        src_idle;
  logic        src_we;
  logic [31:0] src_addr;
  logic [3:0]  src_sel;
  logic [31:0] src_wdata;
  logic        src_err;
  logic        held_err;

  assign src_idle  = (state_q == ST_IDLE);
  assign src_we    = src_idle ? req_we_i    : we_q;
  assign src_addr  = src_idle ? req_addr_i  : addr_q;
  assign src_sel   = src_idle ? req_sel_i   : sel_q;
  assign src_wdata = src_idle ? req_wdata_i : wdata_q;

`ifdef DMEM_ERR_CHECK_EN
  function automatic logic access_err(input logic [31:0] a, input logic [3:0] s);
    return (a[1:0] != 2'b00) || (s == 4'd0) || (a[31:DEPTH_LOG2+2] != '0);
  endfunction
  assign src_err  = access_err(src_addr, src_sel);
  assign held_err = access_err(addr_q, sel_q);
`else
  // Byte offset and upper bits are ignored: addresses wrap modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[31:DEPTH_LOG2+2], src_addr[1:0]};
  assign src_err  = 1'b0;
  assign held_err = 1'b0;
`endif

  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign ram_en = go_resp && !src_err;
  assign ram_we = (src_we == OP_STORE) ? src_sel : 4'd0;

  dmem_ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (src_addr[DEPTH_LOG2+1:2]),
    .wdata_i(src_wdata),
    .rdata_o(ram_rdata)
  );

  // Ready is gated by rst so it reads 0 for the whole reset window.
  assign req_ready_o = (state_q == ST_IDLE) && (rst != RST_ENABLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) && held_err;
  assign rsp_rdata_o = ((state_q == ST_RESP) && (we_q == OP_LOAD) && !held_err)
                       ? (ram_rdata & lane_mask(sel_q)) : ZERO_WORD;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req     [2];
  logic        we      [2];
  logic [31:0] addr    [2];
  logic [3:0]  sel     [2];
  logic [31:0] wdata   [2];
  logic        ready   [2];
  logic        valid   [2];
  logic [31:0] rdata   [2];
  logic        err     [2];
  logic        rsp_rdy [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          in_rsp [2];
  logic [31:0] hold_r [2];
  logic        hold_e [2];
  int          lat    [2];

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_i(req[0]), .req_we_i(we[0]), .req_addr_i(addr[0]), .req_sel_i(sel[0]),
    .req_wdata_i(wdata[0]), .req_ready_o(ready[0]), .rsp_valid_o(valid[0]),
    .rsp_rdata_o(rdata[0]), .rsp_err_o(err[0]), .rsp_ready_i(rsp_rdy[0])
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_i(req[1]), .req_we_i(we[1]), .req_addr_i(addr[1]), .req_sel_i(sel[1]),
    .req_wdata_i(wdata[1]), .req_ready_o(ready[1]), .rsp_valid_o(valid[1]),
    .rsp_rdata_o(rdata[1]), .rsp_err_o(err[1]), .rsp_ready_i(rsp_rdy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, d, act, req_v);
    end
  endtask

  // Monitor: pops an expectation on each new response, then checks stability.
  always @(negedge clk) begin
    exp_t e;
    bit   got;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        in_rsp[d] = 1'b0;
      end else if (valid[d]) begin
        if (!in_rsp[d]) begin
          got = 1'b0;
          if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
          if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
          if (!got) begin
            chk("unexpected_rsp", d, 32'd1, 32'd0);
          end else begin
            chk("rsp_rdata", d, rdata[d], e.rdata);
            chk("rsp_err", d, {31'd0, err[d]}, {31'd0, e.err});
            chk("rsp_latency", d, 32'(cyc - e.acc), 32'(lat[d]));
          end
          in_rsp[d] = 1'b1;
          hold_r[d] = rdata[d];
          hold_e[d] = err[d];
        end else begin
          chk("hold_rdata", d, rdata[d], hold_r[d]);
          chk("hold_err", d, {31'd0, err[d]}, {31'd0, hold_e[d]});
        end
      end else begin
        in_rsp[d] = 1'b0;
        chk("idle_rdata", d, rdata[d], 32'd0);
        chk("idle_err", d, {31'd0, err[d]}, 32'd0);
      end
    end
  end

  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd;
    while (!ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready[d]) begin
      chk("accept_timeout", d, 32'd0, 32'd1);
      req[d] = 1'b0;
      return;
    end
    e.rdata = er; e.err = ee; e.acc = cyc;
    if (push) begin
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    @(negedge clk);
    // Scramble the inputs so only the latched copy can produce the result.
    req[d] = 1'b0; we[d] = ~w; addr[d] = 32'hFFFF_FFFC; sel[d] = ~s; wdata[d] = ~wd;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (!ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", d, {31'd0, ready[d]}, 32'd1);
  endtask

  initial begin
    int n;
    lat[0] = 3;
    lat[1] = 1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; sel[d] = 4'd0; wdata[d] = 32'd0;
      rsp_rdy[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, {31'd0, ready[d]}, 32'd0);
      chk("rst_valid", d, {31'd0, valid[d]}, 32'd0);
      chk("rst_rdata", d, rdata[d], 32'd0);
      chk("rst_err", d, {31'd0, err[d]}, 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("post_rst_ready", d, {31'd0, ready[d]}, 32'd1);

    // Basic stores and lane-masked load (WAIT_CYCLES=2).
    issue(0, 1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 4'b0101, 32'h0, 32'h00AD_00EF, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h0000_0020, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1);

    // Backpressure: response held, second request refused until release.
    wait_idle(0);
    rsp_rdy[0] = 1'b0;
    issue(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    n = 0;
    while (!valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 0, {31'd0, valid[0]}, 32'd1);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; sel[0] = 4'b0011; wdata[0] = 32'h0000_CAFE;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", 0, {31'd0, ready[0]}, 32'd0);
      chk("hold_valid", 0, {31'd0, valid[0]}, 32'd1);
    end
    rsp_rdy[0] = 1'b1;
    issue(0, 1'b1, 32'h0000_0010, 4'b0011, 32'h0000_CAFE, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_CAFE, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 4'b1000, 32'h0, 32'hDE00_0000, 1'b0, 1'b1);

`ifdef DMEM_ERR_CHECK_EN
    issue(0, 1'b0, 32'h0000_0013, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(0, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
`else
    issue(0, 1'b0, 32'h0000_1013, 4'hF, 32'h0, 32'hDEAD_CAFE, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h0000_1000, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
`endif

    // Reset one cycle after accepting a store: store must be abandoned.
    wait_idle(0);
    issue(0, 1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 0, {31'd0, ready[0]}, 32'd0);
    chk("midrst_valid", 0, {31'd0, valid[0]}, 32'd0);
    chk("midrst_rdata", 0, rdata[0], 32'd0);
    chk("midrst_err", 0, {31'd0, err[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 0, {31'd0, ready[0]}, 32'd1);
    issue(0, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b1);

    // Zero wait states.
    issue(1, 1'b1, 32'h0000_0008, 4'hF, 32'h0102_0304, 32'h0, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h0000_0008, 4'b0110, 32'h0, 32'h0002_0300, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 32'h0102_0304, 1'b0, 1'b1);

    n = 0;
    while ((sb0.size() + sb1.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("sb_drain", 0, 32'(sb0.size() + sb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
